// File: rtl/conditional_diff_serial_if.sv
// -----------------------------------------------------------------------------
// conditional_diff_serial_if
//
// Purpose:
//   Groups the request/response signals of the chunk-serial subtractor
//   (conditional_diff_serial) into one bundle. The requester drives the
//   operands and START. The subtractor drives status and the registered result.
//
// Signals (WIDTH = operand/result width):
//   start  requester -> subtractor  request, sampled only when not busy
//   a      requester -> subtractor  minuend, captured on accepted start
//   b      requester -> subtractor  subtrahend, captured on accepted start
//   b_in   requester -> subtractor  borrow-in, captured on accepted start
//   busy   subtractor -> requester  high while chunks are being processed
//   done   subtractor -> requester  single-cycle pulse, result valid
//   d      subtractor -> requester  difference (registered)
//   b_out  subtractor -> requester  final borrow-out
//   ovf    subtractor -> requester  signed two's-complement overflow
//
// Modports:
//   master  requester side (drives start/a/b/b_in)
//   slave   subtractor side (drives busy/done/d/b_out/ovf)
// -----------------------------------------------------------------------------
interface conditional_diff_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             ovf;

    modport master (
        output start,
        output a,
        output b,
        output b_in,
        input  busy,
        input  done,
        input  d,
        input  b_out,
        input  ovf
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  b_in,
        output busy,
        output done,
        output d,
        output b_out,
        output ovf
    );
endinterface

// File: rtl/conditional_diff_serial.sv
// -----------------------------------------------------------------------------
// conditional_diff_serial
//
// Purpose:
//   Multi-cycle WIDTH-bit subtractor computing D = A - B - B_IN, resolving
//   CHUNK bits per clock. Each chunk computes both borrow-in outcomes in
//   parallel (borrow 0 and borrow 1). The borrow registered from the previous
//   chunk then selects one of them. The per-cycle logic depth is therefore one
//   CHUNK-bit subtract plus a 2:1 mux. No borrow chain is wider than CHUNK
//   bits plus the 1-bit borrow register.
//
//   Operation: an accepted start latches the operands and enters BUSY. The
//   next N = WIDTH/CHUNK edges each resolve one chunk, LSB chunk first. The
//   edge that resolves the last chunk publishes D/B_OUT/OVF and enters DONE
//   for exactly one cycle. START in that DONE cycle begins the next operation
//   back-to-back. D/B_OUT/OVF are only written on completion, so they hold
//   their previous value throughout BUSY.
//
//   WIDTH must be an integer multiple of CHUNK.
//
// Parameters:
//   WIDTH  operand/result width in bits
//   CHUNK  bits resolved per clock
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset (clears control and datapath)
//   bus    slave side of conditional_diff_serial_if: start/a/b/b_in in,
//          busy/done/d/b_out/ovf out
// -----------------------------------------------------------------------------
module conditional_diff_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    conditional_diff_serial_if.slave    bus
);
    localparam int                N        = WIDTH / CHUNK;
    localparam int                IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operands latched on an accepted start. They are stable for the whole
    // operation.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    // Partially assembled difference and the borrow feeding the next chunk.
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] work_next;
    logic             borrow_reg;
    logic [IDX_W-1:0] idx;

    // Published result registers.
    logic [WIDTH-1:0] d_reg;
    logic             b_out_reg;
    logic             ovf_reg;

    // Current-chunk datapath.
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] diff0;
    logic [CHUNK-1:0] diff1;
    logic [CHUNK-1:0] diff_sel;
    logic             bo0;
    logic             bo1;
    logic             bo_sel;

    logic             accept;
    logic             last_chunk;
    logic             ovf_next;

    // One CHUNK-bit subtract with explicit borrow-in. The result is widened by
    // one bit, so its MSB is the borrow-out: x - y - bin lies in
    // [-2^CHUNK, 2^CHUNK - 1], and it is negative exactly when the MSB is set.
    // The return value is {borrow_out, difference}.
    function automatic logic [CHUNK:0] chunk_sub(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             bin
    );
        logic [CHUNK:0] r;
        r = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bin};
        return r;
    endfunction

    // Signed overflow of the finished subtraction. It can only happen when the
    // operand signs differ. It is flagged when the result sign disagrees with
    // the minuend sign.
    function automatic logic sub_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb
    );
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    assign a_chunk = a_reg[int'(idx) * CHUNK +: CHUNK];
    assign b_chunk = b_reg[int'(idx) * CHUNK +: CHUNK];

    // Conditional difference: both borrow outcomes are computed in parallel.
    // The borrow registered from the previous chunk only drives the final mux,
    // so it never enters the subtract path.
    always_comb begin
        {bo0, diff0} = chunk_sub(a_chunk, b_chunk, 1'b0);
        {bo1, diff1} = chunk_sub(a_chunk, b_chunk, 1'b1);
        diff_sel     = borrow_reg ? diff1 : diff0;
        bo_sel       = borrow_reg ? bo1   : bo0;

        work_next = work_reg;
        work_next[int'(idx) * CHUNK +: CHUNK] = diff_sel;

        // Uses work_next so the sign bit written by the final chunk is
        // included.
        ovf_next = sub_overflow(a_reg[WIDTH-1], b_reg[WIDTH-1],
                                work_next[WIDTH-1]);
    end

    // Next-state logic. START is honoured only in IDLE and DONE. START in DONE
    // gives back-to-back operation with one result every N+1 cycles.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_chunk = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_BUSY;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (idx == LAST_IDX) begin
                    last_chunk = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            work_reg   <= '0;
            borrow_reg <= 1'b0;
            idx        <= '0;
            d_reg      <= '0;
            b_out_reg  <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (accept) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            borrow_reg <= bus.b_in;
            work_reg   <= '0;
            idx        <= '0;
        end else if (state == ST_BUSY) begin
            work_reg   <= work_next;
            borrow_reg <= bo_sel;
            idx        <= idx + 1'b1;
            // Publish the result only on the final chunk. The outputs are
            // never partially updated.
            if (last_chunk) begin
                d_reg     <= work_next;
                b_out_reg <= bo_sel;
                ovf_reg   <= ovf_next;
            end
        end
    end

    // Status is decoded from the state register, so reset clears it
    // immediately without waiting for a clock.
    assign bus.busy  = (state == ST_BUSY);
    assign bus.done  = (state == ST_DONE);
    assign bus.d     = d_reg;
    assign bus.b_out = b_out_reg;
    assign bus.ovf   = ovf_reg;
endmodule

// File: tb/tb_conditional_diff_serial.sv
// -----------------------------------------------------------------------------
// tb_conditional_diff_serial
//
// Runs three instances (16/4, 8/1, 32/8) side by side. Each instance gets a
// short list of directed operations followed by random ones. A timeline
// reference model predicts busy/done/d/b_out/ovf after every clock edge from
// A - B - B_IN arithmetic. Latency, asynchronous reset and the model itself
// are also pinned with literal expectations.
// -----------------------------------------------------------------------------
module tb_conditional_diff_serial;
    localparam int NCFG   = 3;
    localparam int CFG_W [NCFG] = '{16, 8, 32};
    localparam int CFG_C [NCFG] = '{4, 1, 8};
    localparam int NOPS   = 40;
    localparam int NDIR   = 8;
    localparam int RST_OP = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit fin [NCFG];

    longint unsigned dir_a  [NDIR] = '{64'h1234, 64'h1000, 64'h0000, 64'h8000,
                                       64'h0000, 64'h0005, 64'h1111, 64'h7FFF};
    longint unsigned dir_b  [NDIR] = '{64'h0034, 64'h0001, 64'h0001, 64'h0001,
                                       64'hFFFF, 64'h0003, 64'h1111, 64'hFFFF};
    bit              dir_bi [NDIR] = '{1'b0, 1'b0, 1'b0, 1'b0,
                                       1'b1, 1'b0, 1'b1, 1'b0};
    int              dir_gap[NDIR] = '{0, 1, 0, 0, 1, 0, 0, 0};

    // Reference arithmetic: w-bit modulo subtraction, unsigned borrow-out and
    // the sign-rule overflow flag.
    function automatic void ref_sub(input int w, input longint unsigned a_in,
                                    input longint unsigned b_in_v, input bit bin,
                                    output longint unsigned d, output bit bo,
                                    output bit ov);
        longint unsigned mask;
        longint unsigned a;
        longint unsigned b;
        mask = (64'd1 << w) - 64'd1;
        a    = a_in & mask;
        b    = b_in_v & mask;
        d    = (a - b - longint'(bin)) & mask;
        bo   = (a < b + longint'(bin));
        ov   = (((a >> (w - 1)) & 1) != ((b >> (w - 1)) & 1)) &&
               (((d >> (w - 1)) & 1) != ((a >> (w - 1)) & 1));
    endfunction

    function automatic longint unsigned pick(input int w);
        longint unsigned r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return (64'd1 << w) - 64'd1;
            2:       return 64'd1 << (w - 1);
            default: return r;
        endcase
    endfunction

    task automatic pin(input string name, input int w, input longint unsigned a,
                       input longint unsigned b, input bit bin,
                       input longint unsigned xd, input bit xbo, input bit xov);
        longint unsigned d;
        bit bo;
        bit ov;
        ref_sub(w, a, b, bin, d, bo, ov);
        total++;
        if (d != xd || bo != xbo || ov != xov) begin
            bad++;
            $display("FAIL model_%s: got d=%h bo=%0b ovf=%0b, required d=%h bo=%0b ovf=%0b",
                     name, d, bo, ov, xd, xbo, xov);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int W = CFG_W[g];
        localparam int C = CFG_C[g];
        localparam int N = W / C;

        logic rst;
        conditional_diff_serial_if #(.WIDTH(W)) bus ();
        conditional_diff_serial #(.WIDTH(W), .CHUNK(C)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        // Timeline model. An operation accepted at edge s keeps busy high
        // after edges s..s+N-1. Edge s+N publishes the result and raises done.
        bit              m_active = 1'b0;
        longint unsigned m_s      = 0;
        longint unsigned m_cyc    = 0;
        longint unsigned m_pd     = 0;
        bit              m_pbo    = 1'b0;
        bit              m_pov    = 1'b0;
        bit              e_busy   = 1'b0;
        bit              e_done   = 1'b0;
        longint unsigned e_d      = 0;
        bit              e_bo     = 1'b0;
        bit              e_ov     = 1'b0;

        initial forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_active = 1'b0;
                e_busy   = 1'b0;
                e_done   = 1'b0;
                e_d      = 0;
                e_bo     = 1'b0;
                e_ov     = 1'b0;
            end else begin
                m_cyc++;
                e_done = 1'b0;
                if (m_active) begin
                    if (m_cyc == m_s + N) begin
                        m_active = 1'b0;
                        e_done   = 1'b1;
                        e_d      = m_pd;
                        e_bo     = m_pbo;
                        e_ov     = m_pov;
                    end
                end else if (bus.start) begin
                    m_active = 1'b1;
                    m_s      = m_cyc;
                    ref_sub(W, longint'(bus.a), longint'(bus.b), bus.b_in,
                            m_pd, m_pbo, m_pov);
                end
                e_busy = m_active;
            end
        end

        initial forever begin
            @(negedge clk);
            total++;
            if (bus.busy !== e_busy || bus.done !== e_done ||
                bus.d !== e_d[W-1:0] || bus.b_out !== e_bo || bus.ovf !== e_ov) begin
                bad++;
                $display("FAIL cfg%0d_outputs t=%0t: got busy=%0b done=%0b d=%h bo=%0b ovf=%0b, required busy=%0b done=%0b d=%h bo=%0b ovf=%0b",
                         g, $time, bus.busy, bus.done, bus.d, bus.b_out, bus.ovf,
                         e_busy, e_done, e_d[W-1:0], e_bo, e_ov);
            end
        end

        initial begin
            longint unsigned va;
            longint unsigned vb;
            longint unsigned rv;
            bit vbi;
            bit pulse;
            bit abort;
            int gap;
            int k;
            rst        = 1'b1;
            bus.start  = 1'b0;
            bus.a      = '0;
            bus.b      = '0;
            bus.b_in   = 1'b0;
            repeat (2) @(negedge clk);
            total++;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.d !== '0 ||
                bus.b_out !== 1'b0 || bus.ovf !== 1'b0) begin
                bad++;
                $display("FAIL cfg%0d_reset_state: got busy=%0b done=%0b d=%h bo=%0b ovf=%0b, required all zero",
                         g, bus.busy, bus.done, bus.d, bus.b_out, bus.ovf);
            end
            rst = 1'b0;
            for (int op = 0; op < NOPS; op++) begin
                if (op < NDIR) begin
                    va    = dir_a[op];
                    vb    = dir_b[op];
                    vbi   = dir_bi[op];
                    gap   = dir_gap[op];
                    pulse = (op == 0);
                end else begin
                    va    = pick(W);
                    vb    = pick(W);
                    vbi   = 1'($urandom_range(0, 1));
                    gap   = $urandom_range(0, 2);
                    pulse = ($urandom_range(0, 3) == 0);
                end
                abort = (op == RST_OP);
                @(negedge clk);
                bus.start = 1'b0;
                repeat (gap) @(negedge clk);
                bus.start = 1'b1;
                bus.a     = va[W-1:0];
                bus.b     = vb[W-1:0];
                bus.b_in  = vbi;
                @(posedge clk);
                #1;
                k = 0;
                while (k < 2 * N + 4) begin
                    @(negedge clk);
                    // Operands are scrambled while busy; the latched copy must win.
                    rv        = {$urandom, $urandom};
                    bus.a     = rv[W-1:0];
                    rv        = {$urandom, $urandom};
                    bus.b     = rv[W-1:0];
                    bus.b_in  = 1'($urandom_range(0, 1));
                    bus.start = (pulse && k == 1);
                    @(posedge clk);
                    #1;
                    k++;
                    if (abort && k == 2) break;
                    if (bus.done) break;
                end
                if (abort) begin
                    #2 rst = 1'b1;
                    #1;
                    total++;
                    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.d !== '0 ||
                        bus.b_out !== 1'b0 || bus.ovf !== 1'b0) begin
                        bad++;
                        $display("FAIL cfg%0d_async_reset: got busy=%0b done=%0b d=%h bo=%0b ovf=%0b, required all zero",
                                 g, bus.busy, bus.done, bus.d, bus.b_out, bus.ovf);
                    end
                    @(negedge clk);
                    rst       = 1'b0;
                    bus.start = 1'b0;
                    for (int j = 0; j < N + 2; j++) begin
                        @(posedge clk);
                        #1;
                        total++;
                        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                            bad++;
                            $display("FAIL cfg%0d_quiet_after_reset: got busy=%0b done=%0b, required busy=0 done=0",
                                     g, bus.busy, bus.done);
                        end
                    end
                end else begin
                    total++;
                    if (k != N || bus.done !== 1'b1) begin
                        bad++;
                        $display("FAIL cfg%0d_latency op%0d: got %0d edges after start (done=%0b), required %0d",
                                 g, op, k, bus.done, N);
                    end
                end
            end
            fin[g] = 1'b1;
        end
    end

    initial begin
        bit all_done;
        pin("basic",      16, 64'h1234,     64'h0034, 1'b0, 64'h1200,     1'b0, 1'b0);
        pin("ripple",     16, 64'h1000,     64'h0001, 1'b0, 64'h0FFF,     1'b0, 1'b0);
        pin("wrap",       16, 64'h0000,     64'h0001, 1'b0, 64'hFFFF,     1'b1, 1'b0);
        pin("ovf",        16, 64'h8000,     64'h0001, 1'b0, 64'h7FFF,     1'b0, 1'b1);
        pin("borrow_in",  16, 64'h0000,     64'hFFFF, 1'b1, 64'h0000,     1'b1, 1'b0);
        pin("b2b",        16, 64'h0005,     64'h0003, 1'b0, 64'h0002,     1'b0, 1'b0);
        pin("eq_bin",     16, 64'h1111,     64'h1111, 1'b1, 64'hFFFF,     1'b1, 1'b0);
        pin("w8_wrap",     8, 64'h00,       64'h01,   1'b0, 64'hFF,       1'b1, 1'b0);
        pin("w32_ovf",    32, 64'h80000000, 64'h1,    1'b0, 64'h7FFFFFFF, 1'b0, 1'b1);
        all_done = 1'b0;
        for (int t = 0; t < 50000 && !all_done; t++) begin
            @(posedge clk);
            all_done = fin[0] && fin[1] && fin[2];
        end
        if (!all_done) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got fin=%0b%0b%0b, required 111", fin[0], fin[1], fin[2]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
